// File: rtl/code_lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : code_lock_pkg
//  Brief    : Shared types, default sizes and helpers for the code lock block.
//  Revision : 1.0 - initial release
// ============================================================================
package code_lock_pkg;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_DIGITS      = 4;
    localparam int DEF_MAX_FAIL    = 3;
    localparam int DEF_LOCKOUT_CYC = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTER   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_PROG    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/code_lock_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : code_lock_ctrl_if
//  Brief    : Keypad-side inputs and indicator-side outputs of the code lock.
//  Revision : 1.0 - initial release
// ============================================================================
interface code_lock_ctrl_if
    import code_lock_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DIGITS   = DEF_DIGITS,
    parameter int MAX_FAIL = DEF_MAX_FAIL
);
    localparam int IDX_W  = clog2(DIGITS);
    localparam int FAIL_W = clog2(MAX_FAIL + 1);

    logic [WIDTH-1:0]  digit_in;
    logic              digit_valid;
    logic              prog_mode;
    logic              clear;
    logic              unlocked;
    logic              err;
    logic              alarm;
    logic [IDX_W-1:0]  digit_idx;
    logic [FAIL_W-1:0] fail_cnt;

    // Keypad front end drives digits and strobes
    modport master (
        output digit_in, digit_valid, prog_mode, clear,
        input  unlocked, err, alarm, digit_idx, fail_cnt
    );

    // Lock controller consumes strobes and reports status
    modport slave (
        input  digit_in, digit_valid, prog_mode, clear,
        output unlocked, err, alarm, digit_idx, fail_cnt
    );

endinterface
`default_nettype wire

// File: rtl/code_lock_ctrl_lockout_timer.sv
`default_nettype none
// ============================================================================
//  Module   : lockout_timer
//  Brief    : Loadable down-counter timing the alarm lockout period.
//  Revision : 1.0 - initial release
// ============================================================================
module lockout_timer
    import code_lock_pkg::*;
#(
    parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic load_i,
    input  wire logic en_i,
    output logic      done_o
);
    localparam int               CNT_W    = clog2(LOCKOUT_CYC);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCKOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // Load on lockout entry, then count down to zero and hold there
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/code_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : code_lock_ctrl
//  Brief    : Sequential digit-entry lock with lockout and code reprogramming.
//  Revision : 1.0 - initial release
// ============================================================================
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int                         WIDTH        = DEF_WIDTH,
    parameter int                         DIGITS       = DEF_DIGITS,
    parameter int                         MAX_FAIL     = DEF_MAX_FAIL,
    parameter int                         LOCKOUT_CYC  = DEF_LOCKOUT_CYC,
    parameter logic [DIGITS*WIDTH-1:0]    DEFAULT_CODE = 16'h1234
) (
    input  wire logic       clk,
    input  wire logic       rst,
    code_lock_ctrl_if.slave bus
);
    localparam int                CODE_W   = DIGITS * WIDTH;
    localparam int                IDX_W    = clog2(DIGITS);
    localparam int                FAIL_W   = clog2(MAX_FAIL + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

    state_t            state_q;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] shadow_q;
    logic [CODE_W-1:0] shadow_d;
    logic [IDX_W-1:0]  idx_q;
    logic [FAIL_W-1:0] fail_q;
    logic [FAIL_W-1:0] fail_inc;
    logic              mismatch_q;
    logic              err_pend_q;
    logic              unlocked_q;
    logic              err_q;
    logic              alarm_q;
    logic [WIDTH-1:0]  code_digit;
    logic              digit_neq;
    logic              timer_load;
    logic              timer_done;

    // Select the stored digit at the current index; digit 0 is the top nibble
    always_comb begin
        code_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                code_digit = code_q[(DIGITS-1-i)*WIDTH +: WIDTH];
            end
        end
    end

    // Shadow code with the incoming digit written at the current index
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                shadow_d[(DIGITS-1-i)*WIDTH +: WIDTH] = bus.digit_in;
            end
        end
    end

    assign digit_neq  = (bus.digit_in != code_digit);
    assign fail_inc   = (fail_q == FAIL_MAX) ? fail_q : fail_q + FAIL_W'(1);
    assign timer_load = (state_q == ST_CHECK) && mismatch_q && (fail_inc == FAIL_MAX);

    lockout_timer #(
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) u_lockout_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (timer_load),
        .en_i   (state_q == ST_LOCKOUT),
        .done_o (timer_done)
    );

    // Main controller: state, stored code, counters and registered indicators.
    // Indicators follow the state one cycle later, so unlocked/err rise two
    // edges after the edge that samples the final digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            code_q     <= DEFAULT_CODE;
            shadow_q   <= DEFAULT_CODE;
            idx_q      <= '0;
            fail_q     <= '0;
            mismatch_q <= 1'b0;
            err_pend_q <= 1'b0;
            unlocked_q <= 1'b0;
            err_q      <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            unlocked_q <= (state_q == ST_OPEN) || (state_q == ST_PROG);
            alarm_q    <= (state_q == ST_LOCKOUT);
            err_q      <= err_pend_q;
            err_pend_q <= 1'b0;

            case (state_q)
                ST_IDLE, ST_ENTER: begin
                    if (bus.clear) begin
                        idx_q      <= '0;
                        mismatch_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (bus.digit_valid) begin
                        mismatch_q <= mismatch_q | digit_neq;
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= ST_CHECK;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_ENTER;
                        end
                    end
                end

                ST_CHECK: begin
                    mismatch_q <= 1'b0;
                    if (!mismatch_q) begin
                        fail_q  <= '0;
                        state_q <= ST_OPEN;
                    end else begin
                        fail_q     <= fail_inc;
                        err_pend_q <= 1'b1;
                        state_q    <= (fail_inc == FAIL_MAX) ? ST_LOCKOUT : ST_IDLE;
                    end
                end

                ST_OPEN: begin
                    if (bus.clear) begin
                        state_q <= ST_IDLE;
                    end else if (bus.digit_valid && bus.prog_mode) begin
                        shadow_q <= shadow_d;
                        idx_q    <= IDX_W'(1);
                        state_q  <= ST_PROG;
                    end
                end

                ST_PROG: begin
                    if (bus.clear) begin
                        idx_q   <= '0;
                        state_q <= ST_OPEN;
                    end else if (bus.digit_valid) begin
                        if (idx_q == LAST_IDX) begin
                            code_q  <= shadow_d;
                            idx_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            shadow_q <= shadow_d;
                            idx_q    <= idx_q + IDX_W'(1);
                        end
                    end
                end

                ST_LOCKOUT: begin
                    if (timer_done) begin
                        fail_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.unlocked  = unlocked_q;
    assign bus.err       = err_q;
    assign bus.alarm     = alarm_q;
    assign bus.digit_idx = idx_q;
    assign bus.fail_cnt  = fail_q;

endmodule
`default_nettype wire
